// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream converter: splits each accepted word into up to Ratio beats,
// least-significant slice first, with a registered output and no bubble between words.
module stream_downsizer #(
   parameter int unsigned DataWidth = 8,
   parameter int unsigned Ratio     = 4,
   parameter int unsigned CntWidth  = (Ratio > 1) ? $clog2(Ratio) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clr_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [DataWidth*Ratio-1:0] data_i,
   input  logic [CntWidth-1:0]        num_beats_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [DataWidth-1:0]       data_o,
   output logic                       last_o,
   output logic [CntWidth-1:0]        beat_idx_o
);

   localparam logic [CntWidth-1:0] MaxIdx = CntWidth'(Ratio - 1);

   logic [DataWidth*Ratio-1:0] r_word;
   logic [CntWidth-1:0]        r_last_idx;
   logic [CntWidth-1:0]        r_cnt;
   logic                       r_valid;

   logic                       w_last;
   logic                       w_load;
   logic [CntWidth-1:0]        w_last_idx;
   logic [DataWidth-1:0]       w_data;

   // Saturation only matters when the counter can encode indices past Ratio-1.
   if ((1 << CntWidth) == Ratio) begin : g_no_sat
      assign w_last_idx = num_beats_i;
   end else begin : g_sat
      assign w_last_idx = (num_beats_i > MaxIdx) ? MaxIdx : num_beats_i;
   end

   always_comb begin
      w_data = '0;
      for (int unsigned k = 0; k < Ratio; k++) begin
         if (r_cnt == CntWidth'(k)) begin
            w_data = r_word[k*DataWidth +: DataWidth];
         end
      end
   end

   assign w_last     = r_valid & (r_cnt == r_last_idx);
   assign ready_o    = ~r_valid | (w_last & ready_i);
   assign w_load     = valid_i & ready_o;

   assign valid_o    = r_valid;
   assign data_o     = w_data;
   assign last_o     = w_last;
   assign beat_idx_o = r_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_word     <= '0;
         r_last_idx <= '0;
         r_cnt      <= '0;
         r_valid    <= 1'b0;
      end else if (clr_i) begin
         r_word     <= '0;
         r_last_idx <= '0;
         r_cnt      <= '0;
         r_valid    <= 1'b0;
      end else if (w_load) begin
         r_word     <= data_i;
         r_last_idx <= w_last_idx;
         r_cnt      <= '0;
         r_valid    <= 1'b1;
      end else if (w_last & ready_i) begin
         // Final beat drained with nothing behind it; word stays held.
         r_valid    <= 1'b0;
         r_cnt      <= '0;
      end else if (r_valid & ready_i) begin
         r_cnt      <= r_cnt + CntWidth'(1);
      end
   end

endmodule

// File: tb/tb_stream_downsizer.sv
// Bench for stream_downsizer: Ratio=4 and Ratio=3 instances share stimulus and are checked
// against a queue-of-remaining-beats reference model.
module tb_stream_downsizer;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] idx;
      logic       last;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        valid_in;
   logic [31:0] data_in;
   logic [1:0]  nb_in;
   logic        ready_in;

   logic        ready4, valid4, last4;
   logic [7:0]  data4;
   logic [1:0]  idx4;
   logic        ready3, valid3, last3;
   logic [7:0]  data3;
   logic [1:0]  idx3;

   int checks = 0;
   int failures = 0;
   int beats3 = 0;

   beat_t q4[$];
   beat_t q3[$];

   stream_downsizer #(.DataWidth(8), .Ratio(4)) u_dut4 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clr_i       (clr),
      .valid_i     (valid_in),
      .ready_o     (ready4),
      .data_i      (data_in),
      .num_beats_i (nb_in),
      .valid_o     (valid4),
      .ready_i     (ready_in),
      .data_o      (data4),
      .last_o      (last4),
      .beat_idx_o  (idx4)
   );

   stream_downsizer #(.DataWidth(8), .Ratio(3)) u_dut3 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clr_i       (clr),
      .valid_i     (valid_in),
      .ready_o     (ready3),
      .data_i      (data_in[23:0]),
      .num_beats_i (nb_in),
      .valid_o     (valid3),
      .ready_i     (ready_in),
      .data_o      (data3),
      .last_o      (last3),
      .beat_idx_o  (idx3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_word(input int sel, input logic [31:0] w, input logic [1:0] nb);
      int    r;
      int    n;
      beat_t b;
      r = (sel != 0) ? 3 : 4;
      n = (int'(nb) > r - 1) ? r : int'(nb) + 1;
      for (int k = 0; k < n; k++) begin
         b.data = w[k*8 +: 8];
         b.idx  = 2'(k);
         b.last = (k == n - 1);
         if (sel != 0) q3.push_back(b);
         else          q4.push_back(b);
      end
   endtask

   task automatic check_outs();
      beat_t e;
      check("valid4", {31'b0, valid4}, {31'b0, q4.size() != 0});
      check("ready4", {31'b0, ready4},
            {31'b0, (q4.size() == 0) || (q4.size() == 1 && ready_in)});
      if (q4.size() != 0) begin
         e = q4[0];
         check("data4", {24'b0, data4}, {24'b0, e.data});
         check("idx4", {30'b0, idx4}, {30'b0, e.idx});
         check("last4", {31'b0, last4}, {31'b0, e.last});
      end else begin
         check("last4_idle", {31'b0, last4}, 32'd0);
      end
      check("valid3", {31'b0, valid3}, {31'b0, q3.size() != 0});
      check("ready3", {31'b0, ready3},
            {31'b0, (q3.size() == 0) || (q3.size() == 1 && ready_in)});
      if (q3.size() != 0) begin
         e = q3[0];
         check("data3", {24'b0, data3}, {24'b0, e.data});
         check("idx3", {30'b0, idx3}, {30'b0, e.idx});
         check("last3", {31'b0, last3}, {31'b0, e.last});
      end else begin
         check("last3_idle", {31'b0, last3}, 32'd0);
      end
   endtask

   // Inputs are already driven; check, clock, then advance the model.
   task automatic step();
      logic acc4;
      logic acc3;
      #1;
      check_outs();
      acc4 = valid_in && ((q4.size() == 0) || (q4.size() == 1 && ready_in));
      acc3 = valid_in && ((q3.size() == 0) || (q3.size() == 1 && ready_in));
      @(posedge clk);
      if (clr) begin
         q4.delete();
         q3.delete();
      end else begin
         if (q4.size() != 0 && ready_in) void'(q4.pop_front());
         if (q3.size() != 0 && ready_in) begin
            void'(q3.pop_front());
            beats3++;
         end
         if (acc4) push_word(0, data_in, nb_in);
         if (acc3) push_word(1, {8'h00, data_in[23:0]}, nb_in);
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] nb,
                        input logic rdy, input logic c);
      valid_in = v;
      data_in  = d;
      nb_in    = nb;
      ready_in = rdy;
      clr      = c;
   endtask

   task automatic idle(input int n);
      drive(1'b0, $urandom, 2'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b1, $urandom, 2'($urandom), 1'($urandom), 1'($urandom));

      // Reset with random inputs
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive(1'($urandom), $urandom, 2'($urandom), 1'($urandom), 1'($urandom));
         #1;
         check("rst_valid4", {31'b0, valid4}, 32'd0);
         check("rst_data4", {24'b0, data4}, 32'd0);
         check("rst_last4", {31'b0, last4}, 32'd0);
         check("rst_idx4", {30'b0, idx4}, 32'd0);
         check("rst_ready4", {31'b0, ready4}, 32'd1);
         check("rst_valid3", {31'b0, valid3}, 32'd0);
         check("rst_ready3", {31'b0, ready3}, 32'd1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // Full word
      drive(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b0);
      step();
      idle(5);

      // Back-to-back: second word held until accepted on the 0x44 beat
      drive(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b0);
      step();
      drive(1'b1, 32'h88776655, 2'd3, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step();
      idle(5);

      // Partial word
      drive(1'b1, 32'hDDCCBBAA, 2'd1, 1'b1, 1'b0);
      step();
      idle(3);

      // Backpressure on beat 1
      drive(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_data4", {24'b0, data4}, 32'h22);
         check("stall_idx4", {30'b0, idx4}, 32'd1);
         step();
      end
      idle(4);

      // Clear during beat 2, with a valid word offered in the same cycle
      drive(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      step();
      step();
      drive(1'b1, 32'h12345678, 2'd3, 1'b1, 1'b1);
      #1;
      check("pre_clr_data4", {24'b0, data4}, 32'h33);
      step();
      drive(1'b1, 32'h00CCBBAA, 2'd3, 1'b1, 1'b0);
      step();
      idle(5);

      // Num beats 3 saturates to 3 beats on the Ratio=3 instance
      beats3 = 0;
      drive(1'b1, 32'h00332211, 2'd3, 1'b1, 1'b0);
      step();
      idle(6);
      check("beats3_sat", beats3, 32'd3);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 99) < 60), $urandom, 2'($urandom),
               ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 3));
         step();
      end

      // Asynchronous reset mid-word
      drive(1'b1, 32'hA1B2C3D4, 2'd3, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid4", {31'b0, valid4}, 32'd0);
      check("arst_valid3", {31'b0, valid3}, 32'd0);
      check("arst_data4", {24'b0, data4}, 32'd0);
      q4.delete();
      q3.delete();
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stream_downsizer.md
Name: stream_downsizer

Overview:
- Consumes a wide stream word, for example from a stream register stage, and emits it as Ratio narrow beats over a ready/valid handshake.
- Beats are sent least-significant slice first; last_o marks the final beat of each word.
- An optional per-word beat count allows partial words.
- The output is registered, and back-to-back words stream with no bubble.

Parameters:
- DataWidth, default 8: width of one narrow output beat in bits; must be >= 1.
- Ratio, default 4: number of narrow beats per wide input word; must be >= 1; need not be a power of two.
- CntWidth, default (Ratio > 1) ? $clog2(Ratio) : 1: derived; must not be overridden.

Ports:
- clk_i, input, 1: clock.
- rst_ni, input, 1: asynchronous active-low reset.
- clr_i, input, 1: synchronous clear; drops any held word.
- valid_i, input, 1: input word valid.
- ready_o, output, 1: input word accepted when valid_i & ready_o.
- data_i, input, DataWidth*Ratio: wide word; slice k is bits [k*DataWidth +: DataWidth].
- num_beats_i, input, CntWidth: number of beats to emit minus one; sampled only on acceptance.
- valid_o, output, 1: output beat valid.
- ready_i, input, 1: downstream ready.
- data_o, output, DataWidth: current narrow beat.
- last_o, output, 1: current beat is the final beat of its word.
- beat_idx_o, output, CntWidth: index of the current beat within its word.

Behaviour:
- State:
  - word_q, DataWidth*Ratio bits.
  - last_idx_q, CntWidth bits.
  - cnt_q, CntWidth bits.
  - valid_q, 1 bit.
  - Two logical states: EMPTY (valid_q = 0) and BUSY (valid_q = 1).
- Reset (rst_ni = 0, asynchronous):
  - All state registers go to 0.
  - Resulting outputs: valid_o = 0, data_o = 0, last_o = 0, beat_idx_o = 0, ready_o = 1.
- Outputs:
  - valid_o = valid_q.
  - data_o = slice cnt_q of word_q.
  - beat_idx_o = cnt_q.
  - last_o = valid_q & (cnt_q == last_idx_q).
- Ready: ready_o = ~valid_q | (last_o & ready_i). This is combinational from ready_i; the path is not cut.
- Beat advance (valid_o & ready_i & ~last_o): cnt_q increments by 1. No wrap is needed, because cnt_q never exceeds last_idx_q.
- Word load (valid_i & ready_o):
  - word_q <= data_i.
  - last_idx_q <= min(num_beats_i, Ratio-1). Out-of-range values saturate to Ratio-1.
  - cnt_q <= 0; valid_q <= 1.
- Final beat with no new word (last_o & ready_i & ~valid_i): valid_q <= 0 and cnt_q <= 0. word_q is held.
- Simultaneous final beat and new input: load takes effect, so the next cycle shows beat 0 of the new word. No bubble.
- Latency: first beat of an accepted word appears on valid_o the cycle after acceptance.
- Throughput: one beat per cycle under no backpressure.
- Stall (valid_o & ~ready_i): data_o, last_o, beat_idx_o and valid_o are held stable. Once asserted, valid_o never deasserts without a handshake, except on clr_i or reset.
- Clear (clr_i = 1 at clock edge):
  - Takes priority over load and advance.
  - valid_q, cnt_q, last_idx_q and word_q all go to 0.
  - Any partially emitted word is discarded.
  - The input handshake in that cycle is ignored: the word is not stored even if valid_i & ready_o.
- Ratio = 1: behaves as a single-entry registered stage with last_o = valid_o and beat_idx_o = 0. num_beats_i is ignored.
- Reset mid-word: the word is discarded immediately. No output beat occurs until a new word is accepted.

Test Plan:
Scenarios 1-5 use DataWidth=8, Ratio=4; scenario 6 uses Ratio=3.
1. Reset:
   - Stimulus: assert rst_ni=0 for 2 cycles with random inputs.
   - Response: valid_o=0, data_o=0x00, last_o=0, beat_idx_o=0, ready_o=1 throughout.
2. Full word:
   - Stimulus: data_i=0x44332211, num_beats_i=3, ready_i=1.
   - Response: over the next 4 cycles data_o=0x11,0x22,0x33,0x44 with beat_idx_o=0..3.
   - last_o=1 only on 0x44; ready_o=0 during beats 0-2 and 1 during beat 3.
3. Back-to-back:
   - Stimulus: words 0x44332211 then 0x88776655, valid_i held high, ready_i=1.
   - Response: 8 contiguous beats 0x11..0x88 with no gap; the second word is accepted in the cycle showing 0x44.
4. Partial word and saturation:
   - Stimulus: num_beats_i=1 with 0xDDCCBBAA.
   - Response: 0xAA then 0xBB with last_o=1; 0xCC and 0xDD are never emitted.
5. Backpressure:
   - Stimulus: during beat 1 of 0x44332211, drop ready_i to 0 for 3 cycles.
   - Response: data_o=0x22, beat_idx_o=1, valid_o=1 held for those 3 cycles; 0x33 follows once ready_i returns to 1.
6. Clear and Ratio=3 saturation:
   - Part A:
     - Stimulus: assert clr_i for 1 cycle while beat 2 (0x33) is shown.
     - Response: next cycle valid_o=0, ready_o=1. A following word 0x00CCBBAA starts at beat_idx_o=0 with data_o=0xAA.
   - Part B, with Ratio=3:
     - Stimulus: num_beats_i=3.
     - Response: exactly 3 beats are emitted; last_o=1 at beat_idx_o=2.
